// File: rtl/mbisr_pkg.sv
// Shared types and defaults for the MBISR memory responder and its remap CAM.
// Remap entries are packed as {vld, addr}, with the valid flag just above the address field.
package mbisr_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int SPARES_DEF = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ALLOC = 1'b1
  } state_t;

  // Bit position of the valid flag inside a {vld, addr} remap entry.
  function automatic int ent_vld_bit(input int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/mbisr_remap_cam.sv
// Remap table: SPARES {vld, addr} entries with an access lookup, a repair lookup,
// a lowest-index free-entry encoder and an allocate port.
module mbisr_remap_cam
  import mbisr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SPARES = SPARES_DEF,
  localparam int IDX_W = (SPARES > 1) ? $clog2(SPARES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [IDX_W-1:0]  lookup_idx,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic              alloc_en,
  output logic              alloc_hit,
  output logic              free_avail,
  output logic [IDX_W-1:0]  free_idx,
  output logic [2:0]        used_cnt
);

  localparam int VLD = ent_vld_bit(ADDR_W);

  logic [ADDR_W:0] ent [SPARES];

  always_comb begin
    lookup_hit = 1'b0;
    lookup_idx = '0;
    alloc_hit  = 1'b0;
    free_avail = 1'b0;
    free_idx   = '0;
    used_cnt   = '0;
    for (int i = 0; i < SPARES; i++) begin
      if (ent[i][VLD] && ent[i][ADDR_W-1:0] == lookup_addr) begin
        lookup_hit = 1'b1;
        lookup_idx = IDX_W'(i);
      end
      if (ent[i][VLD] && ent[i][ADDR_W-1:0] == alloc_addr) begin
        alloc_hit = 1'b1;
      end
      used_cnt = used_cnt + 3'(ent[i][VLD]);
    end
    // Scan downwards so the lowest free index is the one left standing.
    for (int i = SPARES - 1; i >= 0; i--) begin
      if (!ent[i][VLD]) begin
        free_avail = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPARES; i++) begin
        ent[i] <= '0;
      end
    end else if (alloc_en) begin
      ent[free_idx] <= {1'b1, alloc_addr};
    end
  end

endmodule

// File: rtl/mbisr_mem_responder.sv
// Memory-side responder for the MBIST/MBISR engine: flop word array, spare words and repair FSM.
// Optional MBISR_FAULT_INJ_EN forces data bit 0 to 0 on main-array writes to FAULT_ADDR.
module mbisr_mem_responder
  import mbisr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SPARES = SPARES_DEF
`ifdef MBISR_FAULT_INJ_EN
  ,
  parameter logic [ADDR_W-1:0] FAULT_ADDR = ADDR_W'(5)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              rep_valid,
  input  logic [ADDR_W-1:0] rep_addr,
  output logic              rep_ack,
  output logic              rep_full,
  output logic [2:0]        rep_cnt,
  output state_t            dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = (SPARES > 1) ? $clog2(SPARES) : 1;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_valid/req_addr/req_we/req_wdata must stay stable until then. A pending repair wins.
  state_t            state;
  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] spare [SPARES];
  logic [ADDR_W-1:0] rep_addr_q;
  logic              acc;
  logic              acc_hit;
  logic [IDX_W-1:0]  acc_idx;
  logic              alloc_hit;
  logic              alloc_en;
  logic              free_avail;
  logic [IDX_W-1:0]  free_idx;
  logic [DATA_W-1:0] wdata_main;

  assign req_ready = (state == S_IDLE) && !rep_valid;
  assign acc       = req_valid && req_ready;
  assign alloc_en  = (state == S_ALLOC) && !alloc_hit && free_avail;
  assign dbg_state = state;

`ifdef MBISR_FAULT_INJ_EN
  assign wdata_main = (req_addr == FAULT_ADDR) ? {req_wdata[DATA_W-1:1], 1'b0} : req_wdata;
`else
  assign wdata_main = req_wdata;
`endif

  mbisr_remap_cam #(
    .ADDR_W(ADDR_W),
    .SPARES(SPARES)
  ) u_cam (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_addr(req_addr),
    .lookup_hit (acc_hit),
    .lookup_idx (acc_idx),
    .alloc_addr (rep_addr_q),
    .alloc_en   (alloc_en),
    .alloc_hit  (alloc_hit),
    .free_avail (free_avail),
    .free_idx   (free_idx),
    .used_cnt   (rep_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < SPARES; i++) spare[i] <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rep_ack    <= 1'b0;
      rep_full   <= 1'b0;
      rep_addr_q <= '0;
      state      <= S_IDLE;
    end else begin
      rsp_valid <= acc && !req_we;
      rep_ack   <= 1'b0;
      if (acc) begin
        if (req_we) begin
          if (acc_hit) spare[acc_idx] <= req_wdata;
          else         mem[req_addr]  <= wdata_main;
        end else begin
          rsp_rdata <= acc_hit ? spare[acc_idx] : mem[req_addr];
        end
      end
      case (state)
        S_IDLE: begin
          if (rep_valid) begin
            rep_addr_q <= rep_addr;
            state      <= S_ALLOC;
          end
        end
        S_ALLOC: begin
          // Accesses are blocked here, so clearing the new spare cannot race a write.
          if (alloc_hit) begin
            rep_ack <= 1'b1;
          end else if (free_avail) begin
            spare[free_idx] <= '0;
            rep_ack         <= 1'b1;
          end else begin
            rep_full <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbisr_mem_responder.sv
// Directed self-checking bench for mbisr_mem_responder (honours MBISR_FAULT_INJ_EN when defined).
module tb_mbisr_mem_responder;
  import mbisr_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_we = 1'b0;
  logic [3:0]   req_addr = '0;
  logic [7:0]   req_wdata = '0;
  logic         req_ready;
  logic         rsp_valid;
  logic [7:0]   rsp_rdata;
  logic         rep_valid = 1'b0;
  logic [3:0]   rep_addr = '0;
  logic         rep_ack;
  logic         rep_full;
  logic [2:0]   rep_cnt;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  mbisr_mem_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rep_valid(rep_valid),
    .rep_addr (rep_addr),
    .rep_ack  (rep_ack),
    .rep_full (rep_full),
    .rep_cnt  (rep_cnt),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rep_valid = 1'b0; rep_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drivers: each starts and ends at a falling edge.
  task automatic wait_ready(input string who);
    int n = 0;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL %s_timeout req_ready stuck at 0 for %0d cycles", who, n);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    wait_ready("write");
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [7:0] d, output logic v);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    wait_ready("read");
    @(posedge clk); @(negedge clk);
    v = rsp_valid; d = rsp_rdata;
    req_valid = 1'b0;
  endtask

  task automatic do_repair(input logic [3:0] a, output logic ack, output logic full);
    rep_valid = 1'b1; rep_addr = a;
    @(posedge clk); @(negedge clk);
    rep_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    ack = rep_ack; full = rep_full;
  endtask

  // Tests
  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata got %h want 00", rsp_rdata); end
    checks++; if (rep_ack !== 1'b0) begin errors++; $display("FAIL reset_rep_ack got %b want 0", rep_ack); end
    checks++; if (rep_full !== 1'b0) begin errors++; $display("FAIL reset_rep_full got %b want 0", rep_full); end
    checks++; if (rep_cnt !== 3'd0) begin errors++; $display("FAIL reset_rep_cnt got %0d want 0", rep_cnt); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want S_IDLE", dbg_state); end
    @(negedge clk);
  endtask

  task automatic test_read_all();
    int pulses = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
          errors++; $display("FAIL read_all_%0d got v=%b d=%h want v=1 d=00", i - 1, rsp_valid, rsp_rdata);
        end
        if (rsp_valid === 1'b1) pulses++;
      end
      if (i < 16) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(i);
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_all_idle got v=%b want 0", rsp_valid); end
    checks++; if (pulses != 16) begin errors++; $display("FAIL read_all_pulses got %0d want 16", pulses); end
  endtask

  task automatic test_write_read();
    logic [7:0] d; logic v;
    do_write(4'd3, 8'hA5);
    do_read(4'd3, d, v);
    checks++; if (v !== 1'b1 || d !== 8'hA5) begin errors++; $display("FAIL write_read got v=%b d=%h want v=1 d=a5", v, d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'((i << 4) | (15 - i)));
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
          errors++; $display("FAIL b2b_read_%0d got v=%b d=%h want v=1 d=%h", i - 1, rsp_valid, rsp_rdata, exp);
        end
      end
      if (i < 16) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(i);
        exp_q.push_back(8'((i << 4) | (15 - i)));
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_hold();
    logic [7:0] d; logic v;
    do_read(4'd3, d, v);
    checks++; if (v !== 1'b1 || d !== 8'h3C) begin errors++; $display("FAIL hold_read got v=%b d=%h want v=1 d=3c", v, d); end
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h3C) begin errors++; $display("FAIL hold_data got v=%b d=%h want v=0 d=3c", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_fault();
    logic [7:0] d; logic v, ack, full;
    logic [7:0] exp_faulty;
`ifdef MBISR_FAULT_INJ_EN
    exp_faulty = 8'hFE;
`else
    exp_faulty = 8'hFF;
`endif
    apply_reset();
    do_write(4'd5, 8'hFF);
    do_read(4'd5, d, v);
    checks++; if (v !== 1'b1 || d !== exp_faulty) begin errors++; $display("FAIL fault_pre got v=%b d=%h want v=1 d=%h", v, d, exp_faulty); end
    do_repair(4'd5, ack, full);
    checks++; if (ack !== 1'b1 || full !== 1'b0 || rep_cnt !== 3'd1) begin errors++; $display("FAIL fault_repair got ack=%b full=%b cnt=%0d want 1 0 1", ack, full, rep_cnt); end
    do_write(4'd5, 8'hFF);
    do_read(4'd5, d, v);
    checks++; if (v !== 1'b1 || d !== 8'hFF) begin errors++; $display("FAIL fault_post got v=%b d=%h want v=1 d=ff", v, d); end
    do_write(4'd4, 8'hFF);
    do_read(4'd4, d, v);
    checks++; if (v !== 1'b1 || d !== 8'hFF) begin errors++; $display("FAIL fault_addr4 got v=%b d=%h want v=1 d=ff", v, d); end
  endtask

  task automatic test_repair();
    logic [7:0] d; logic v, ack, full;
    apply_reset();
    do_write(4'd2, 8'h33);
    do_repair(4'd2, ack, full);
    checks++; if (ack !== 1'b1 || full !== 1'b0 || rep_cnt !== 3'd1) begin errors++; $display("FAIL rep2 got ack=%b full=%b cnt=%0d want 1 0 1", ack, full, rep_cnt); end
    do_read(4'd2, d, v);
    checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL rep2_spare_clear got v=%b d=%h want v=1 d=00", v, d); end
    do_write(4'd2, 8'h44);
    do_read(4'd2, d, v);
    checks++; if (v !== 1'b1 || d !== 8'h44) begin errors++; $display("FAIL rep2_spare_rw got v=%b d=%h want v=1 d=44", v, d); end
    do_repair(4'd7, ack, full);
    checks++; if (ack !== 1'b1 || full !== 1'b0 || rep_cnt !== 3'd2) begin errors++; $display("FAIL rep7 got ack=%b full=%b cnt=%0d want 1 0 2", ack, full, rep_cnt); end
    do_write(4'd7, 8'h77);
    do_read(4'd2, d, v);
    checks++; if (v !== 1'b1 || d !== 8'h44) begin errors++; $display("FAIL rep_spares_distinct got v=%b d=%h want v=1 d=44", v, d); end
    do_repair(4'd9, ack, full);
    checks++; if (ack !== 1'b0 || full !== 1'b1 || rep_cnt !== 3'd2) begin errors++; $display("FAIL rep9_full got ack=%b full=%b cnt=%0d want 0 1 2", ack, full, rep_cnt); end
    do_repair(4'd7, ack, full);
    checks++; if (ack !== 1'b1 || full !== 1'b1 || rep_cnt !== 3'd2) begin errors++; $display("FAIL rep7_dup got ack=%b full=%b cnt=%0d want 1 1 2", ack, full, rep_cnt); end
    do_read(4'd7, d, v);
    checks++; if (v !== 1'b1 || d !== 8'h77) begin errors++; $display("FAIL rep7_dup_data got v=%b d=%h want v=1 d=77", v, d); end
  endtask

  task automatic test_priority();
    apply_reset();
    do_write(4'd6, 8'h77);
    rep_valid = 1'b1; rep_addr = 4'd1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd6;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_rep got %b want 0", req_ready); end
    @(posedge clk); @(negedge clk);
    rep_valid = 1'b0;
    #1;
    checks++; if (dbg_state !== S_ALLOC || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL prio_alloc got st=%0d rdy=%b v=%b want 1 0 0", dbg_state, req_ready, rsp_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (rep_ack !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL prio_ack got ack=%b rdy=%b v=%b want 1 1 0", rep_ack, req_ready, rsp_valid); end
    @(posedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h77) begin errors++; $display("FAIL prio_held_read got v=%b d=%h want v=1 d=77", rsp_valid, rsp_rdata); end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic v;
    apply_reset();
    do_write(4'd8, 8'h5C);
    rep_valid = 1'b1; rep_addr = 4'd8;
    @(posedge clk); @(negedge clk);
    rep_valid = 1'b0;
    #1;
    checks++; if (dbg_state !== S_ALLOC) begin errors++; $display("FAIL rstmid_in_alloc got st=%0d want 1", dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++; if (rep_ack !== 1'b0 || rep_cnt !== 3'd0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL rstmid_alloc got ack=%b cnt=%0d st=%0d want 0 0 0", rep_ack, rep_cnt, dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (rep_ack !== 1'b0 || rep_cnt !== 3'd0) begin errors++; $display("FAIL rstmid_after got ack=%b cnt=%0d want 0 0", rep_ack, rep_cnt); end
    do_write(4'd8, 8'h5C);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd8;
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL rstmid_read got v=%b d=%h want v=0 d=00", rsp_valid, rsp_rdata); end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    do_read(4'd8, d, v);
    checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL rstmid_cleared got v=%b d=%h want v=1 d=00", v, d); end
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_write_read();
    test_back_to_back();
    test_hold();
    test_fault();
    test_repair();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
